// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg
// Shared definitions for the memory-side responder of the CPU memory bus.
// Holds the bus word size, the default access latency (also referenced by
// the CPU side for its own timeouts), the counter width and the FSM
// state encoding.
package memory_responder_pkg;

  // Width of the CPU address and data buses.
  localparam int WORD_SIZE = 16;

  // Default clock edges from request acceptance to the input_ready cycle.
  localparam int DEFAULT_LATENCY = 2;

  // Wide enough for LATENCY-2 with LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/memory_responder_mem_array.sv
// memory_responder_mem_array
// 2^AW x DW word storage: one synchronous write port, one asynchronous read
// port. No reset, so contents survive a bus reset; contents are undefined
// until written.
// Ports:
//   clk    in   write clock
//   we     in   write enable, sampled on the rising edge
//   addr   in   shared read/write word address
//   wdata  in   write data
//   rdata  out  combinational read of mem[addr]
module memory_responder_mem_array #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_responder.sv
// memory_responder
// Memory-side end of the CPU memory bus. A read or write request seen in
// IDLE is captured (address, operation, write data) and completed LATENCY
// cycles later with a one-cycle input_ready pulse. Reads drive the shared
// data bus only during that completion cycle; writes commit to the array
// on the edge leaving it.
//
// Handshake: the CPU raises read_m or write_m and holds it (with address,
// and data for writes) until it sees input_ready high at a rising edge.
// Dropping both requests before completion aborts the access. After every
// completion the block spends one cycle in IDLE before it accepts again.
//
// Ports:
//   clk          in    system clock, rising edge
//   reset_n      in    asynchronous active-low reset
//   read_m       in    read request (wins over write_m when both are high)
//   write_m      in    write request
//   address      in    word address; bits above MEM_AW are ignored
//   data         inout shared data bus, driven here only in a read's DONE cycle
//   input_ready  out   one-cycle completion pulse
//   busy         out   high from acceptance through the DONE cycle
//   dbg_state    out   current FSM state (state_e encoding)
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int MEM_AW  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 input_ready,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // WAIT is entered with LATENCY-2 so that DONE lands LATENCY cycles after
  // acceptance; LATENCY=1 bypasses WAIT entirely.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MEM_AW-1:0]    addr_q, addr_d;
  logic                 is_read_q, is_read_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;

  logic                 mem_we;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 drive_rd;

  // Upper address bits are deliberately dropped: addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[WORD_SIZE-1:MEM_AW];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    wdata_d     = wdata_q;
    input_ready = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_m || write_m) begin
          addr_d    = address[MEM_AW-1:0];
          is_read_d = read_m;
          wdata_d   = data;
          if (LATENCY == 1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // Abort takes priority over reaching the end of the count.
        if (!read_m && !write_m) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        input_ready = 1'b1;
        // Array write happens on the edge leaving DONE; an asynchronous
        // reset during DONE clears state_q and so drops the write.
        mem_we      = !is_read_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      is_read_q <= is_read_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  memory_responder_mem_array #(
    .AW (MEM_AW),
    .DW (WORD_SIZE)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rd_data)
  );

  // The only state in which this block owns the bus.
  assign drive_rd = (state_q == ST_DONE) && is_read_q;
  assign data     = drive_rd ? rd_data : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
// Directed bench for memory_responder. Four instances with LATENCY 2, 1, 5
// and 4 share one set of request signals; sel routes the request to one
// instance and muxes that instance's outputs back for checking.
module tb_memory_responder;
  import memory_responder_pkg::*;

  localparam int LAT_TAB [4] = '{2, 1, 5, 4};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        rd, wr, oe;
  logic [15:0] addr, wval;
  int          sel;

  wire  [15:0] data_0, data_1, data_2, data_3;
  logic        ir_0, ir_1, ir_2, ir_3;
  logic        busy_0, busy_1, busy_2, busy_3;
  logic [1:0]  st_0, st_1, st_2, st_3;

  assign data_0 = (oe && sel == 0) ? wval : 'z;
  assign data_1 = (oe && sel == 1) ? wval : 'z;
  assign data_2 = (oe && sel == 2) ? wval : 'z;
  assign data_3 = (oe && sel == 3) ? wval : 'z;

  memory_responder #(.LATENCY(LAT_TAB[0]), .MEM_AW(8)) u_dut_l2 (
    .clk(clk), .reset_n(reset_n), .read_m(rd && sel == 0), .write_m(wr && sel == 0),
    .address(addr), .data(data_0), .input_ready(ir_0), .busy(busy_0), .dbg_state(st_0));
  memory_responder #(.LATENCY(LAT_TAB[1]), .MEM_AW(8)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .read_m(rd && sel == 1), .write_m(wr && sel == 1),
    .address(addr), .data(data_1), .input_ready(ir_1), .busy(busy_1), .dbg_state(st_1));
  memory_responder #(.LATENCY(LAT_TAB[2]), .MEM_AW(8)) u_dut_l5 (
    .clk(clk), .reset_n(reset_n), .read_m(rd && sel == 2), .write_m(wr && sel == 2),
    .address(addr), .data(data_2), .input_ready(ir_2), .busy(busy_2), .dbg_state(st_2));
  memory_responder #(.LATENCY(LAT_TAB[3]), .MEM_AW(8)) u_dut_l4 (
    .clk(clk), .reset_n(reset_n), .read_m(rd && sel == 3), .write_m(wr && sel == 3),
    .address(addr), .data(data_3), .input_ready(ir_3), .busy(busy_3), .dbg_state(st_3));

  logic [15:0] data_obs;
  logic        ir_obs, busy_obs;
  logic [1:0]  st_obs;

  always_comb begin
    data_obs = data_0; ir_obs = ir_0; busy_obs = busy_0; st_obs = st_0;
    case (sel)
      1: begin data_obs = data_1; ir_obs = ir_1; busy_obs = busy_1; st_obs = st_1; end
      2: begin data_obs = data_2; ir_obs = ir_2; busy_obs = busy_2; st_obs = st_2; end
      3: begin data_obs = data_3; ir_obs = ir_3; busy_obs = busy_3; st_obs = st_3; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Counts falling edges until input_ready is seen (n = 0 on timeout),
  // tallying busy cycles and any cycle where the bus differs from the
  // value this bench is driving.
  task automatic wait_ir(input int max_cyc, output int n, output int busy_cnt,
                         output int bus_err, output logic [15:0] seen);
    n = 0; busy_cnt = 0; bus_err = 0; seen = '0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (busy_obs) busy_cnt++;
      if (oe && (data_obs !== wval)) bus_err++;
      if (ir_obs) begin
        n    = i;
        seen = data_obs;
        break;
      end
    end
  endtask

  // One complete access on instance k. Requests are driven just after a
  // rising edge with the DUT idle, so acceptance is at the next edge and
  // input_ready shows up LATENCY+1 falling edges after the drive.
  task automatic do_access(input int k, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] v,
                           input logic [15:0] exp_rd, input string tag);
    int n, bc, be;
    logic [15:0] seen;
    sel = k;
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; wval = v; oe = w && !r;
    if (r) exp_q.push_back(exp_rd);
    wait_ir(LAT_TAB[k] + 4, n, bc, be, seen);
    check_eq({tag, "_lat"}, n - 1, LAT_TAB[k]);
    check_eq({tag, "_busy_cycles"}, bc, LAT_TAB[k]);
    if (r) check_eq({tag, "_rdata"}, seen, exp_q.pop_front());
    if (oe) check_eq({tag, "_bus_free"}, be, 0);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; oe = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ir_pulse"}, ir_obs, 1'b0);
    check_eq({tag, "_idle_busy"}, busy_obs, 1'b0);
  endtask

  // Request dropped at the start of the second cycle after acceptance.
  task automatic do_abort(input int k, input logic r, input logic [15:0] a,
                          input logic [15:0] v, input string tag);
    int irs;
    sel = k;
    @(posedge clk); #1;
    rd = r; wr = !r; addr = a; wval = v; oe = !r;
    @(posedge clk);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; oe = 1'b0;
    irs = 0;
    for (int i = 0; i < LAT_TAB[k] + 3; i++) begin
      @(negedge clk);
      if (ir_obs) irs++;
    end
    check_eq({tag, "_no_ready"}, irs, 0);
    check_eq({tag, "_state"}, st_obs, ST_IDLE);
    check_eq({tag, "_busy"}, busy_obs, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, bc, be;
    logic [15:0] seen;
    reset_n = 1'b0; rd = 1'b0; wr = 1'b0; oe = 1'b0;
    addr = '0; wval = '0; sel = 0;

    #3;
    for (int k = 0; k < 4; k++) begin
      sel = k; #1;
      check_eq("rst_ready", ir_obs, 1'b0);
      check_eq("rst_busy", busy_obs, 1'b0);
      check_eq("rst_state", st_obs, ST_IDLE);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Write then read, LATENCY=2.
    do_access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, "l2_wr");
    do_access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "l2_rd");

    // Latency sweep on preloaded 0x1234.
    do_access(1, 1'b0, 1'b1, 16'h0008, 16'h1234, 16'h0000, "l1_wr");
    do_access(1, 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h1234, "l1_rd");
    do_access(2, 1'b0, 1'b1, 16'h0008, 16'h1234, 16'h0000, "l5_wr");
    do_access(2, 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h1234, "l5_rd");

    // Aborts with LATENCY=4.
    do_access(3, 1'b0, 1'b1, 16'h0020, 16'h0077, 16'h0000, "l4_wr");
    do_abort(3, 1'b1, 16'h0020, 16'h0000, "abort_rd");
    do_abort(3, 1'b0, 16'h0020, 16'h9999, "abort_wr");
    do_access(3, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0077, "abort_chk");

    // Address wrap and read-over-write priority.
    do_access(0, 1'b0, 1'b1, 16'h0105, 16'h00AA, 16'h0000, "wrap_wr");
    do_access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h00AA, "wrap_rd");
    do_access(0, 1'b0, 1'b1, 16'h0030, 16'h4321, 16'h0000, "prio_pre");
    do_access(0, 1'b1, 1'b1, 16'h0030, 16'hDEAD, 16'h4321, "prio_both");
    do_access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h4321, "prio_chk");

    // Reset during WAIT of a write (LATENCY=5).
    do_access(2, 1'b0, 1'b1, 16'h0040, 16'h1111, 16'h0000, "rst_pre");
    @(posedge clk); #1;
    wr = 1'b1; addr = 16'h0040; wval = 16'h5555; oe = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check_eq("rst_mid_busy_before", busy_obs, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_ready", ir_obs, 1'b0);
    check_eq("rst_mid_busy", busy_obs, 1'b0);
    check_eq("rst_mid_state", st_obs, ST_IDLE);
    wr = 1'b0; oe = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    do_access(2, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1111, "rst_post");

    // Back-to-back reads on LATENCY=2.
    sel = 0;
    @(posedge clk); #1;
    rd = 1'b1; addr = 16'h0010; oe = 1'b0;
    wait_ir(8, n, bc, be, seen);
    check_eq("b2b_first_lat", n - 1, 2);
    check_eq("b2b_first_rdata", seen, 16'hBEEF);
    @(posedge clk); #1;
    addr = 16'h0005;
    wait_ir(8, n, bc, be, seen);
    check_eq("b2b_gap", n, 3);
    check_eq("b2b_second_rdata", seen, 16'h00AA);
    @(posedge clk); #1;
    rd = 1'b0;
    @(negedge clk);
    check_eq("b2b_idle", busy_obs, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
